hazard_ctrl_unit: RTL

- Generalised forwarding and hazard controller for the 5-stage pipeline.
- Selects EX operand sources from MEM/WB, detects load-use hazards in ID, and sequences multi-cycle EX stalls with a counter FSM.
- Holds taken-branch flushes for a configurable penalty and keeps saturating stall/flush event counters.
- Sits beside the pipeline registers and drives their stall/flush enables.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_unit_fwd_sel.sv | 30 +++
 rtl/hazard_ctrl_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// the multi-cycle stall FSM state.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_WB_ALU = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_WB_LD  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Forwarding source select for one EX operand; MEM beats WB, x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    input  logic              load_w,
    output fwd_sel_t          sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = regwrite_m && (rd_m != '0) && (rd_m == rs);
        wb_hit  = regwrite_w && (rd_w != '0) && (rd_w == rs);
        sel     = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = load_w ? FWD_WB_LD : FWD_WB_ALU;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Forwarding, load-use, multi-cycle EX stall and branch flush control for the
// 5-stage pipeline, with saturating stall/flush event counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_LAT     = 4,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              load_e,
    input  logic              mc_start_e,
    input  logic              branch_taken_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    input  logic              load_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              mc_busy
);

    localparam int MCW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [MCW-1:0] MC_INIT  = MCW'(MC_LAT - 2);
    localparam logic [1:0]     PEN_INIT = 2'(BR_PENALTY - 1);

    mc_state_t        state;
    logic [MCW-1:0]   mc_cnt;
    logic [1:0]       pen_cnt;
    fwd_sel_t         sel_a;
    fwd_sel_t         sel_b;
    logic             lu_hit;
    logic             lu_stall;
    logic             br_accept;
    logic             busy;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs(rs1_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .rd_w(rd_w), .regwrite_w(regwrite_w), .load_w(load_w), .sel(sel_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs(rs2_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .rd_w(rd_w), .regwrite_w(regwrite_w), .load_w(load_w), .sel(sel_b)
    );

    // Combinational terms are gated by rst_n so every output is quiet in reset.
    always_comb begin
        busy      = (state == MC_BUSY);
        lu_hit    = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        br_accept = rst_n && !busy && branch_taken_e;
        lu_stall  = rst_n && !busy && lu_hit && !branch_taken_e;
        fwd_a_e   = rst_n ? sel_a : FWD_RF;
        fwd_b_e   = rst_n ? sel_b : FWD_RF;
        stall_f   = busy || lu_stall;
        stall_d   = busy || lu_stall;
        stall_e   = busy;
        flush_m   = busy;
        flush_e   = br_accept || lu_stall;
        flush_d   = br_accept || (pen_cnt != '0);
        mc_busy   = busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mc_cnt  <= '0;
            pen_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mc_start_e) begin
                        state  <= MC_BUSY;
                        mc_cnt <= MC_INIT;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        mc_cnt <= mc_cnt - MCW'(1);
                    end
                end
                default: state <= RUN;
            endcase

            if (br_accept) begin
                pen_cnt <= PEN_INIT;
            end else if (pen_cnt != '0) begin
                pen_cnt <= pen_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_accept && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
